nibble_serial_sub: RTL
======================

# nibble_serial_sub

Multi-cycle wide subtractor that sits upstream of the 4-bit subtractor datapath. It accepts a WIDTH-bit operand pair plus borrow-in over a valid/ready handshake and processes it one 4-bit nibble per clock, LSB nibble first, chaining the borrow between nibbles. It returns the full difference and the final borrow-out on a second valid/ready handshake. It gives the 4-bit arithmetic stage wide-operand capability without widening its combinational path.

## Interface
- NIBBLES, 4: number of 4-bit nibbles per operand; legal range 1..8.
- WIDTH, 4*NIBBLES: operand and result width. Derived; must not be overridden independently.

- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- bin  input  1  borrow-in to nibble 0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- diff  output  WIDTH  (a - b - bin) mod 2^WIDTH.
- bout  output  1  final borrow; 1 iff a < b + bin (unsigned).
- busy  output  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture a, b and bin into internal registers, clear nibble index to 0, and go to RUN.
- RUN:
  - Each edge computes nibble k: d_k = a_k - b_k - borrow, where borrow is bin for k=0 and the previous nibble's borrow otherwise.
  - Writes d_k into diff[4k+3:4k], stores the new borrow, and increments k.
  - On the edge that processes k=NIBBLES-1, load bout from the final borrow and go to DONE.
- DONE:
  - out_valid=1; diff and bout held stable.
  - On an edge with out_ready=1, go to IDLE.
- Only the captured copies feed the arithmetic. Changes to a, b or bin after acceptance have no effect.
- in_valid is ignored outside IDLE. in_ready=0 in RUN and DONE, so there is no accept in the same cycle as the output handshake.
- Nibble borrow rule: borrow_out = 1 iff a_k < b_k + borrow_in, with 5-bit intermediate arithmetic.
- diff bits for nibbles not yet processed keep their previous value during RUN. Consumers read diff only while out_valid=1.

## Timing
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE immediately.
  - in_ready=1, out_valid=0, busy=0, diff=0, bout=0; nibble index and borrow are cleared.
- Latency:
  - Acceptance edge E0.
  - Nibbles processed on edges E1..E_NIBBLES.
  - out_valid rises after edge E_NIBBLES: 4 cycles for NIBBLES=4.
- Throughput: at most one operation per NIBBLES+2 cycles (accept, NIBBLES compute edges, output handshake edge).
- Back-pressure: out_valid stays high and diff/bout stay unchanged for any number of cycles while out_ready=0.
- out_ready while out_valid=0 has no effect.
- Reset mid-operation, in RUN or DONE: the operation is discarded with no output produced. The block restarts in IDLE when rst_n deasserts.
- NIBBLES=1: RUN lasts exactly one edge.
- Wrap-around: underflow wraps modulo 2^WIDTH with bout=1. No saturation.

## Test plan
- Reset: assert rst_n=0 mid-RUN with a=0x1234, b=0x0234 -> outputs immediately at reset values, no out_valid after release; next operation computes correctly.
- Basic: a=0x1234, b=0x0234, bin=0 -> out_valid exactly 4 edges after accept, diff=0x1000, bout=0.
- Underflow with borrow chain: a=0x0003, b=0x0009, bin=0 -> diff=0xFFFA, bout=1. Also a=0x0000, b=0x0000, bin=1 -> diff=0xFFFF, bout=1.
- Extremes: a=0xFFFF, b=0xFFFF, bin=1 -> diff=0xFFFF, bout=1. a=0xFFFF, b=0x0000, bin=0 -> diff=0xFFFF, bout=0.
- Back-pressure and operand isolation: hold out_ready=0 for 3 cycles after out_valid and toggle a, b and in_valid during RUN/DONE -> diff and bout stable, in_ready=0 throughout, result matches the captured operands.
- Back-to-back random: 200 random operations with random in_valid/out_ready gaps -> every result equals the (a-b-bin) mod 2^16 / borrow reference; no lost or duplicated results.

Source files
------------

// File: rtl/nibble_serial_sub.sv
// Wide unsigned subtractor that works one 4-bit nibble per clock, LSB first.
// The borrow is chained between nibbles; the result is returned over a valid/ready handshake.
module nibble_serial_sub #(
  parameter int NIBBLES = 4,
  parameter int WIDTH   = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [4:0]       nib_r;

  // Bit 4 of the 5-bit result is the borrow out: set iff x < y + bi.
  function automatic logic [4:0] sub_nibble(input logic [3:0] x, input logic [3:0] y,
                                            input logic bi);
    return {1'b0, x} - {1'b0, y} - {4'b0000, bi};
  endfunction

  assign nib_r = sub_nibble(a_q[4*idx_q +: 4], b_q[4*idx_q +: 4], borrow_q);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          idx_d    = '0;
          borrow_d = bin;
          state_d  = RUN;
        end
      end
      RUN: begin
        diff_d[4*idx_q +: 4] = nib_r[3:0];
        borrow_d             = nib_r[4];
        idx_d                = IDX_W'(idx_q + 1'b1);
        if (idx_q == LAST_IDX) begin
          bout_d  = nib_r[4];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  // Operand copies are pure data; only the captured values feed the arithmetic.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      a_q <= a;
      b_q <= b;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign diff      = diff_q;
  assign bout      = bout_q;

endmodule
